// File: rtl/wsp_1500_pkg.sv
// Shared types and constants for the IEEE 1500 wrapper serial port driver.
package wsp_1500_pkg;

    typedef enum logic [1:0] {
        DR_SCAN = 2'd0,
        IR_SCAN = 2'd1,
        WRST    = 2'd2,
        NOP     = 2'd3
    } wsp_op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        CAPTURE = 3'd2,
        SHIFT   = 3'd3,
        UPDATE  = 3'd4,
        RST     = 3'd5,
        RESP    = 3'd6
    } wsp_state_t;

    localparam logic [3:0] WS_BYPASS  = 4'hF;
    localparam logic [3:0] WS_EXTEST  = 4'h0;
    localparam logic [3:0] WS_PRELOAD = 4'h1;

    function automatic logic is_scan(input wsp_op_t op);
        return (op == DR_SCAN) || (op == IR_SCAN);
    endfunction

endpackage

// File: rtl/wsp_wrck_gen.sv
// WRCK generator: clk/2 while active, parked low otherwise; flags the falling edge.
module wsp_wrck_gen (
    input  logic clk,
    input  logic nreset,
    input  logic active_i,
    output logic wrck_o,
    output logic fall_o
);

    logic phase_q;
    logic phase_d;

    // Phase toggles only while a scan/reset sequence runs, so wrck always resumes from 0.
    always_comb begin
        phase_d = active_i ? ~phase_q : 1'b0;
    end

    // Phase register; doubles as the registered wrck output.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign wrck_o = phase_q;
    assign fall_o = phase_q;

endmodule

// File: rtl/wsp_1500_driver.sv
// IEEE 1500 WSP initiator: IR/DR scans and wrapper reset from a valid/ready command channel.
// Optional expected/mask comparison of captured data is enabled by defining WSP_DRV_COMPARE_EN.
module wsp_1500_driver
    import wsp_1500_pkg::*;
#(
    parameter int IR_SIZE     = 4,
    parameter int DR_MAX      = 128,
    parameter int CNT_W       = $clog2(DR_MAX + 1),
    parameter int RST_PERIODS = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
`ifdef WSP_DRV_COMPARE_EN
    input  logic [DR_MAX-1:0] cmd_expect,
    input  logic [DR_MAX-1:0] cmd_mask,
    output logic              rsp_mismatch,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              wrck,
    output logic              wrstn,
    output logic              wsi,
    input  logic              wso,
    output logic              select_wir,
    output logic              capture_wr,
    output logic              shift_wr,
    output logic              update_wr
);

    localparam int IDX_W = $clog2(DR_MAX);

    wsp_state_t        state_q, state_d;
    wsp_op_t           op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [DR_MAX-1:0] data_q, data_d;
    logic [DR_MAX-1:0] rsp_q, rsp_d;
    logic [IDX_W-1:0]  idx_s;
    logic              accept_s;
    logic              active_s;
    logic              fall_s;

    logic wrstn_q, wrstn_d;
    logic wsi_q, wsi_d;
    logic sel_q, sel_d;
    logic cap_q, cap_d;
    logic shift_q, shift_d;
    logic upd_q, upd_d;
    logic cmd_ready_q, cmd_ready_d;
    logic rsp_valid_q, rsp_valid_d;

    assign accept_s = cmd_valid && cmd_ready_q;
    assign active_s = state_q inside {SETUP, CAPTURE, SHIFT, UPDATE, RST};

    wsp_wrck_gen u_wrck_gen (
        .clk      (clk),
        .nreset   (nreset),
        .active_i (active_s),
        .wrck_o   (wrck),
        .fall_o   (fall_s)
    );

    // Next state: every period-level transition happens on the wrck falling edge.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        data_d  = data_q;
        rsp_d   = rsp_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_d   = wsp_op_t'(cmd_op);
                    data_d = cmd_data;
                    rsp_d  = '0;
                    case (wsp_op_t'(cmd_op))
                        DR_SCAN: begin
                            len_d   = (cmd_len > CNT_W'(DR_MAX)) ? CNT_W'(DR_MAX) : cmd_len;
                            cnt_d   = len_d;
                            state_d = SETUP;
                        end
                        IR_SCAN: begin
                            len_d   = CNT_W'(IR_SIZE);
                            cnt_d   = len_d;
                            state_d = SETUP;
                        end
                        WRST: begin
                            len_d   = '0;
                            cnt_d   = CNT_W'(RST_PERIODS);
                            state_d = RST;
                        end
                        default: begin
                            len_d   = '0;
                            state_d = RESP;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                // SETUP doubles as the wrstn-high settling period after a wrapper reset.
                if (fall_s) begin
                    state_d = (op_q == WRST) ? RESP : CAPTURE;
                end else begin
                    state_d = SETUP;
                end
            end
            CAPTURE: begin
                if (fall_s) begin
                    state_d = (len_q == '0) ? UPDATE : SHIFT;
                end else begin
                    state_d = CAPTURE;
                end
            end
            SHIFT: begin
                if (fall_s) begin
                    rsp_d   = {rsp_q[DR_MAX-2:0], wso};
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? UPDATE : SHIFT;
                end else begin
                    state_d = SHIFT;
                end
            end
            UPDATE: begin
                if (fall_s) begin
                    state_d = RESP;
                end else begin
                    state_d = UPDATE;
                end
            end
            RST: begin
                if (fall_s) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? SETUP : RST;
                end else begin
                    state_d = RST;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin values are decoded from the next state so they update on the same edge as the FSM.
    always_comb begin
        idx_s       = IDX_W'(cnt_d - CNT_W'(1));
        wsi_d       = (state_d == SHIFT) ? data_d[idx_s] : 1'b0;
        sel_d       = (op_d == IR_SCAN) && (state_d inside {SETUP, CAPTURE, SHIFT, UPDATE});
        cap_d       = (state_d == CAPTURE);
        shift_d     = (state_d == SHIFT);
        upd_d       = (state_d == UPDATE);
        wrstn_d     = (state_d != RST);
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // State, command context and registered pin outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            op_q        <= DR_SCAN;
            cnt_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            rsp_q       <= '0;
            wrstn_q     <= 1'b0;
            wsi_q       <= 1'b0;
            sel_q       <= 1'b0;
            cap_q       <= 1'b0;
            shift_q     <= 1'b0;
            upd_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            data_q      <= data_d;
            rsp_q       <= rsp_d;
            wrstn_q     <= wrstn_d;
            wsi_q       <= wsi_d;
            sel_q       <= sel_d;
            cap_q       <= cap_d;
            shift_q     <= shift_d;
            upd_q       <= upd_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef WSP_DRV_COMPARE_EN
    logic [DR_MAX-1:0] expect_q, expect_d;
    logic [DR_MAX-1:0] mask_q, mask_d;
    logic [DR_MAX-1:0] lenmask_s;
    logic              mismatch_q, mismatch_d;

    // Compare against the final captured data; only scans can report a mismatch.
    always_comb begin
        expect_d   = accept_s ? cmd_expect : expect_q;
        mask_d     = accept_s ? cmd_mask : mask_q;
        lenmask_s  = ~({DR_MAX{1'b1}} << len_d);
        mismatch_d = ((state_d == RESP) && is_scan(op_d)) ?
                     (|((rsp_d ^ expect_d) & mask_d & lenmask_s)) : 1'b0;
    end

    // Compare context and registered mismatch flag.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            expect_q   <= '0;
            mask_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            expect_q   <= expect_d;
            mask_q     <= mask_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign rsp_mismatch = mismatch_q;
`endif

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_q;
    assign wrstn      = wrstn_q;
    assign wsi        = wsi_q;
    assign select_wir = sel_q;
    assign capture_wr = cap_q;
    assign shift_wr   = shift_q;
    assign update_wr  = upd_q;

endmodule

// File: tb/tb_wsp_1500_driver.sv
// Self-checking bench for wsp_1500_driver: behavioural 1500 wrapper plus transaction-level model.
module tb_wsp_1500_driver;
    import wsp_1500_pkg::*;

    localparam int DRM = 128;
    localparam int CW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           nreset, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]     cmd_op;
    logic [CW-1:0]  cmd_len;
    logic [DRM-1:0] cmd_data, rsp_data;
    logic           wrck, wrstn, wsi, select_wir, capture_wr, shift_wr, update_wr;
    logic           wso = 1'b0;
`ifdef WSP_DRV_COMPARE_EN
    logic [DRM-1:0] cmd_expect, cmd_mask;
    logic           rsp_mismatch;
`endif

    wsp_1500_driver dut (
        .clk(clk), .nreset(nreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
`ifdef WSP_DRV_COMPARE_EN
        .cmd_expect(cmd_expect), .cmd_mask(cmd_mask), .rsp_mismatch(rsp_mismatch),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .wrck(wrck), .wrstn(wrstn), .wsi(wsi), .wso(wso),
        .select_wir(select_wir), .capture_wr(capture_wr),
        .shift_wr(shift_wr), .update_wr(update_wr)
    );

    function automatic logic [DRM-1:0] lmask(input int len);
        if (len >= DRM) return '1;
        return (128'd1 << len) - 128'd1;
    endfunction

    // Behavioural wrapper: MSB-out shift chains, WSO launched on the falling WRCK edge.
    logic [3:0]     ir_sh = '0, ir_out = '0, ir_cap = '0;
    logic [DRM-1:0] dr_sh = '0, dr_out = '0, dr_cap = '0, wsi_vec = '0;
    int             dr_len = 0;
    int n_rise = 0, n_shift = 0, n_cap = 0, n_upd = 0, n_rstlow = 0, n_sel = 0;

    always @(posedge wrck) begin
        n_rise   <= n_rise + 1;
        n_shift  <= n_shift + (shift_wr ? 1 : 0);
        n_cap    <= n_cap + (capture_wr ? 1 : 0);
        n_upd    <= n_upd + (update_wr ? 1 : 0);
        n_rstlow <= n_rstlow + (wrstn ? 0 : 1);
        n_sel    <= n_sel + (select_wir ? 1 : 0);
        if (capture_wr) begin
            if (select_wir) ir_sh <= ir_cap;
            else            dr_sh <= dr_cap;
        end
        if (shift_wr) begin
            wsi_vec <= {wsi_vec[DRM-2:0], wsi};
            if (select_wir) ir_sh <= {ir_sh[2:0], wsi};
            else            dr_sh <= {dr_sh[DRM-2:0], wsi};
        end
        if (update_wr) begin
            if (select_wir) ir_out <= ir_sh;
            else            dr_out <= dr_sh & lmask(dr_len);
        end
    end

    always @(negedge wrck) begin
        wso <= select_wir ? ir_sh[3] : ((dr_len > 0) ? dr_sh[dr_len-1] : 1'b0);
    end

    // Pins must not move across a rising WRCK edge.
    wire [7:0] pins_s = {wrstn, wsi, select_wir, capture_wr, shift_wr, update_wr, cmd_ready, rsp_valid};
    logic [7:0] pins_prev = '0;
    int n_glitch = 0;
    always @(negedge clk) begin
        if (wrck && (pins_s != pins_prev)) n_glitch <= n_glitch + 1;
        pins_prev <= pins_s;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [DRM-1:0] got, input logic [DRM-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [CW-1:0] len, input logic [DRM-1:0] data);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ready_drop", cmd_ready, 0);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] len,
                           input logic [DRM-1:0] data, input int hold);
        int L, t, b_rise, b_shift, b_cap, b_upd, b_rst, b_sel;
        logic scan;
        logic [DRM-1:0] er, held;
        scan = (op == DR_SCAN) || (op == IR_SCAN);
        L = (op == IR_SCAN) ? 4 : (op == DR_SCAN) ? ((int'(len) > DRM) ? DRM : int'(len)) : 0;
        if (op == DR_SCAN) dr_len = L;
        er = (op == IR_SCAN) ? {124'd0, ir_cap} : (op == DR_SCAN) ? (dr_cap & lmask(L)) : '0;
        b_rise = n_rise; b_shift = n_shift; b_cap = n_cap; b_upd = n_upd; b_rst = n_rstlow; b_sel = n_sel;
        send_cmd(op, len, data);
        t = 0;
        while (!rsp_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_timeout", rsp_valid, 1);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, held);
            chk("hold_no_ready", cmd_ready, 0);
        end
        chk("rsp_data", rsp_data, er);
`ifdef WSP_DRV_COMPARE_EN
        chk("rsp_mismatch", rsp_mismatch, scan ? |((er ^ cmd_expect) & cmd_mask & lmask(L)) : 1'b0);
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_release", rsp_valid, 0);
        chk("ready_back", cmd_ready, 1);
        chk("n_shift", n_shift - b_shift, L);
        chk("n_capture", n_cap - b_cap, scan ? 1 : 0);
        chk("n_update", n_upd - b_upd, scan ? 1 : 0);
        chk("n_wrstn_low", n_rstlow - b_rst, (op == WRST) ? 4 : 0);
        chk("n_wrck", n_rise - b_rise, scan ? L + 3 : (op == WRST) ? 5 : 0);
        chk("n_sel_wir", n_sel - b_sel, (op == IR_SCAN) ? 7 : 0);
        if (scan && L > 0) chk("wsi_seq", wsi_vec & lmask(L), data & lmask(L));
        if (op == IR_SCAN) chk("ir_update", ir_out, data[3:0]);
        if (op == DR_SCAN && L > 0) chk("dr_update", dr_out, data & lmask(L));
    endtask

    initial begin
        int t, b;
        logic [DRM-1:0] rd;
        nreset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;
`ifdef WSP_DRV_COMPARE_EN
        cmd_expect = '0; cmd_mask = '0;
`endif
        repeat (5) begin
            @(negedge clk);
            chk("reset_pins", {wrck, pins_s}, 0);
            chk("reset_rsp_data", rsp_data, 0);
        end
        nreset = 1'b1;
        @(negedge clk);
        chk("release_wrstn", wrstn, 1);
        chk("release_ready", cmd_ready, 1);
        chk("release_wrck", wrck, 0);

        ir_cap = 4'b0101;
        run_cmd(IR_SCAN, 8'd0, 128'h1, 0);
        chk("ir_preload", ir_out, WS_PRELOAD);
        dr_cap = 128'h3C;
        run_cmd(DR_SCAN, 8'd8, 128'hA5, 0);
        chk("dr_a5", dr_out, 128'hA5);
        run_cmd(DR_SCAN, 8'd0, {$urandom, $urandom, $urandom, $urandom}, 0);
        dr_cap = {$urandom, $urandom, $urandom, $urandom};
        run_cmd(DR_SCAN, 8'd133, {$urandom, $urandom, $urandom, $urandom}, 0);
        run_cmd(WRST, 8'd0, '0, 10);
        run_cmd(NOP, 8'd0, '1, 2);

`ifdef WSP_DRV_COMPARE_EN
        dr_cap = 128'h3C; cmd_mask = 128'hFF;
        cmd_expect = 128'h3C;
        run_cmd(DR_SCAN, 8'd8, 128'h5A, 0);
        cmd_expect = 128'h3D;
        run_cmd(DR_SCAN, 8'd8, 128'h5A, 0);
`endif

        // Abort an L=16 DR scan part way through SHIFT.
        dr_len = 16; dr_cap = 128'hBEEF;
        b = n_shift;
        send_cmd(DR_SCAN, 8'd16, 128'h1234);
        t = 0;
        while ((n_shift - b) < 5 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("midrst_in_shift", shift_wr, 1);
        nreset = 1'b0;
        #1;
        chk("midrst_pins", {wrck, pins_s}, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        nreset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_no_rsp_after", rsp_valid, 0);
        run_cmd(DR_SCAN, 8'd16, 128'hC3A5, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]    op;
            logic [CW-1:0] len;
            int            r;
            op = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            len = (r == 0) ? 8'd0 : (r == 1) ? 8'($urandom_range(129, 255)) :
                  (r == 2) ? 8'd128 : 8'($urandom_range(1, 127));
            ir_cap = 4'($urandom);
            dr_cap = {$urandom, $urandom, $urandom, $urandom};
            rd     = {$urandom, $urandom, $urandom, $urandom};
`ifdef WSP_DRV_COMPARE_EN
            cmd_mask   = {$urandom, $urandom, $urandom, $urandom};
            cmd_expect = ($urandom_range(0, 1) == 0) ? (op == IR_SCAN ? {124'd0, ir_cap} : dr_cap) : rd;
`endif
            run_cmd(op, len, rd, $urandom_range(0, 3));
        end

        chk("pin_stability", n_glitch, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
